// File: rtl/rv32_defs.sv
// Shared definitions for the instruction-memory loader: loader state encoding
// and the image header width.
package rv32_defs;

  localparam int HDR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } ld_state_e;

endpackage

// File: rtl/byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word. The completed word is
// presented combinationally in the same cycle its fourth byte is offered.
module byte_packer (
  input  logic        clk,
  input  logic        clear,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] shreg;

  // The fourth byte bypasses the register so the caller can latch the word on
  // the very edge that accepts it.
  assign word_valid = data_valid && (lane == 2'd3);
  assign word       = {data_in, shreg};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      lane  <= 2'd0;
      shreg <= 24'd0;
    end else if (data_valid) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    shreg[7:0]   <= data_in;
        2'd1:    shreg[15:8]  <= data_in;
        2'd2:    shreg[23:16] <= data_in;
        default: shreg        <= shreg;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a byte stream (16-bit word count header, then
// little-endian words) and holds the core in reset until the image is complete.
module imem_loader
  import rv32_defs::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          im_we,
  output logic [AW-1:0] im_waddr,
  output logic [31:0]   im_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output logic [15:0]   words_loaded
);

  localparam logic [HDR_W-1:0] DEPTH_N = HDR_W'(DEPTH_WORDS);

  ld_state_e        state_q, state_d;
  logic [7:0]       hdr_lo;
  logic [HDR_W-1:0] n_words;
  logic [HDR_W-1:0] hdr_n;
  logic             accept;
  logic             start_ok;
  logic             all_in;
  logic             pk_valid;
  logic [31:0]      pk_word;

  assign hdr_n  = {rx_data, hdr_lo};
  assign all_in = (words_loaded == n_words);
  assign accept = rx_valid && rx_ready;

  // Once the last word's final byte is taken, the stream is closed for the
  // one cycle spent retiring that write before DONE.
  always_comb begin
    unique case (state_q)
      ST_HDR0, ST_HDR1: rx_ready = 1'b1;
      ST_DATA:          rx_ready = !all_in;
      default:          rx_ready = 1'b0;
    endcase
  end

  assign cpu_hold = (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_ERR);

  byte_packer u_packer (
    .clk        (clk),
    .clear      (rst || start_ok),
    .data_in    (rx_data),
    .data_valid (accept && (state_q == ST_DATA)),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  // NOTE: every signal written here gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d  = ST_HDR0;
          start_ok = 1'b1;
        end
      end
      ST_HDR0: begin
        if (accept) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        if (accept) begin
          if (hdr_n == '0)          state_d = ST_DONE;
          else if (hdr_n > DEPTH_N) state_d = ST_ERR;
          else                      state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (all_in) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hdr_lo       <= 8'd0;
      n_words      <= '0;
      words_loaded <= 16'd0;
      im_we        <= 1'b0;
      im_waddr     <= '0;
      im_wdata     <= 32'd0;
    end else begin
      state_q <= state_d;
      im_we   <= pk_valid;
      if (start_ok) begin
        words_loaded <= 16'd0;
      end
      if (accept && (state_q == ST_HDR0)) begin
        hdr_lo <= rx_data;
      end
      if (accept && (state_q == ST_HDR1)) begin
        n_words <= hdr_n;
      end
      // The word count doubles as the write index; it never exceeds N-1 here
      // because oversized headers never reach DATA.
      if (pk_valid) begin
        im_waddr     <= words_loaded[AW-1:0];
        im_wdata     <= pk_word;
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: the driver predicts each memory
// write from the image contents, a monitor compares every im_we pulse.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [7:0]  im_waddr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[256];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_WORDS(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .im_we        (im_we),
    .im_waddr     (im_waddr),
    .im_wdata     (im_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (im_we === 1'b1) begin
        n_writes++;
        check("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("im_waddr", 32'(im_waddr), e.addr);
          check("im_wdata", im_wdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_im_we"}, 32'(im_we), 32'd0);
    check({tag, "_im_waddr"}, 32'(im_waddr), 32'd0);
    check({tag, "_im_wdata"}, im_wdata, 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_rx_ready", 32'(rx_ready), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_err", 32'(err), 32'd0);
    check("start_words_loaded", 32'(words_loaded), 32'd0);
  endtask

  // Offers one byte after a random number of idle cycles and returns just
  // after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input int idle_pct, input bit pulse_start);
    int waited = 0;
    while (int'($urandom_range(99)) < idle_pct) begin
      rx_valid = 1'b0;
      tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    end
    if (pulse_start) start = 1'b1;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  // Streams header n and img[0..n-1]; stops after abort_at bytes when >= 0.
  task automatic load(input int n, input int idle_pct, input int abort_at, input bit mid_start);
    logic [7:0] bytes[$];
    int total;
    bytes.push_back(8'(n));
    bytes.push_back(8'(n >> 8));
    if (n <= 256) begin
      for (int i = 0; i < n; i++)
        for (int j = 0; j < 4; j++)
          bytes.push_back(8'(img[i] >> (8 * j)));
    end
    total = (abort_at >= 0) ? abort_at : bytes.size();
    for (int i = 0; i < n && n <= 256; i++) begin
      if (2 + 4 * (i + 1) <= total) exp_q.push_back('{addr: i, data: img[i]});
    end
    for (int k = 0; k < total; k++) begin
      send_byte(bytes[k], idle_pct, mid_start && (k == 7));
    end
  endtask

  // After the last data byte: stream closes, then DONE on the next edge.
  task automatic check_completion(input string tag, input int n, input int writes_before);
    check({tag, "_rx_ready_closed"}, 32'(rx_ready), 32'd0);
    check({tag, "_done_not_yet"}, 32'(done), 32'd0);
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_im_we_low"}, 32'(im_we), 32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'(n));
    check({tag, "_write_count"}, 32'(n_writes - writes_before), 32'(n));
    check({tag, "_waddr_hold"}, 32'(im_waddr), 32'(n - 1));
    check({tag, "_wdata_hold"}, im_wdata, img[n - 1]);
  endtask

  initial begin
    int w0;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    check("idle_hold", 32'(cpu_hold), 32'd1);

    // Reference image from the test plan.
    img[0] = 32'h00100513; img[1] = 32'h00A505B3; img[2] = 32'h0000006F;
    do_start();
    w0 = n_writes;
    load(3, 0, -1, 1'b0);
    check_completion("n3", 3, w0);

    // Empty image: DONE directly at the second header byte.
    do_start();
    w0 = n_writes;
    load(0, 0, -1, 1'b0);
    check("n0_done", 32'(done), 32'd1);
    check("n0_cpu_hold", 32'(cpu_hold), 32'd0);
    check("n0_rx_ready", 32'(rx_ready), 32'd0);
    repeat (2) tick();
    check("n0_no_write", 32'(n_writes - w0), 32'd0);
    check("n0_words_loaded", 32'(words_loaded), 32'd0);

    // Oversized header: error, core held, nothing written.
    do_start();
    w0 = n_writes;
    load(257, 0, -1, 1'b0);
    check("n257_err", 32'(err), 32'd1);
    check("n257_rx_ready", 32'(rx_ready), 32'd0);
    check("n257_cpu_hold", 32'(cpu_hold), 32'd1);
    check("n257_done", 32'(done), 32'd0);
    repeat (3) tick();
    check("n257_no_write", 32'(n_writes - w0), 32'd0);
    check("n257_err_sticky", 32'(err), 32'd1);
    do_start();

    // N=8 with random idle cycles, continuing from the HDR0 that start gave.
    for (int i = 0; i < 8; i++) img[i] = $urandom;
    w0 = n_writes;
    load(8, 30, -1, 1'b0);
    check_completion("n8_idle", 8, w0);

    // Same image back to back.
    do_start();
    w0 = n_writes;
    load(8, 0, -1, 1'b0);
    check_completion("n8_b2b", 8, w0);

    // Reset after two bytes of word 1 in an N=4 load.
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    do_start();
    w0 = n_writes;
    load(4, 0, 8, 1'b0);
    rst = 1'b1;
    tick();
    check_reset_values("midrst");
    rst = 1'b0;
    check("midrst_one_write", 32'(n_writes - w0), 32'd1);
    check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

    // Fresh N=4 image with a start pulse during DATA, which must be ignored.
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    tick();
    do_start();
    w0 = n_writes;
    load(4, 20, -1, 1'b1);
    check_completion("n4_midstart", 4, w0);

    repeat (3) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes instruction memory from an 8-bit byte stream and holds the core in reset until the image is complete. It is the write side of the instruction memory: the core's fetch path reads words by word index, and this block fills those words before the first fetch. It sits between a byte source (UART receiver or bench driver) and the instruction memory write port. Its `cpu_hold` output is ORed into the core reset.

## Interface
- `DEPTH_WORDS`, 256: instruction memory depth in 32-bit words.
- `AW`, `$clog2(DEPTH_WORDS)`: word-address width.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin a load.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: the loader accepts a byte this cycle.
- `im_we` out 1: instruction memory write strobe, one-cycle pulse.
- `im_waddr` out AW: word index for the write.
- `im_wdata` out 32: word to write.
- `cpu_hold` out 1: holds the core in reset while high.
- `done` out 1: the image loaded successfully.
- `err` out 1: the header requested more words than `DEPTH_WORDS`.
- `words_loaded` out 16: count of words written.

## Operation
- Stream format:
  - 2-byte header N, little-endian (first byte is N[7:0]).
  - Then 4·N data bytes; each word is little-endian (first byte goes to bits [7:0]).
- A byte is accepted on any edge where `rx_valid && rx_ready`.
- States and transitions:
  - IDLE → HDR0 on `start`.
  - HDR0 → HDR1 on byte accept.
  - HDR1, on byte accept:
    - N==0 → DONE.
    - N>DEPTH_WORDS → ERR.
    - otherwise → DATA.
  - DATA stays in DATA until word N-1 is written, then → DONE.
  - DONE or ERR → HDR0 on `start`. This clears `done`, `err` and `words_loaded` and resets the word index to 0.
- `start` is ignored in HDR0, HDR1 and DATA.
- `rx_ready` is 1 only in HDR0, HDR1 and DATA. In DATA it remains 1 during write-pulse cycles, and bytes keep assembling into the next word.
- Words are written to indices 0..N-1 in order.
- `im_waddr` and `im_wdata` are registered. They hold their last values when `im_we` is 0.
- `words_loaded` is 16 bits wide, so N up to 65535 is representable. N>DEPTH_WORDS is rejected before any write.
- `cpu_hold` is 1 in every state except DONE. ERR keeps the core held.
- Memory contents are never cleared by this block.

## Timing
- Reset values: `rx_ready`=0, `im_we`=0, `im_waddr`=0, `im_wdata`=0, `cpu_hold`=1, `done`=0, `err`=0, `words_loaded`=0. State is IDLE and the byte counter is 0.
- `start` high at edge t: state is HDR0 and `rx_ready`=1 after edge t.
- 4th byte of word i accepted at edge k:
  - During cycle k→k+1: `im_we`=1, `im_waddr`=i, `im_wdata`=word.
  - `words_loaded`=i+1 from edge k.
- Last word (i=N-1) accepted at edge k:
  - `rx_ready`=0 from edge k.
  - At edge k+1: state DONE, `done`=1, `cpu_hold`=0, `im_we`=0.
- Header byte 2 accepted at edge k:
  - N==0: `done`=1, `cpu_hold`=0 from edge k, with no write.
  - N>DEPTH_WORDS: `err`=1 from edge k.
- Throughput is one byte per cycle, so one word every 4 cycles with no bubbles.
- `rst` high at any edge, including mid-word, mid-header or during a write pulse:
  - All outputs take their reset values after that edge.
  - A partial word is discarded.
  - Writes already performed remain in memory.
- `start` and `rst` in the same cycle: `rst` wins.

## Structure
- Shared package `rv32_defs` holds:
  - Loader state encoding (IDLE, HDR0, HDR1, DATA, DONE, ERR; 3 bits).
  - Header width constant (16).
- Sub-module `byte_packer`:
  - 4-byte little-endian shift/assemble register with a 2-bit lane counter.
  - Emits a one-cycle `word_valid` and a 32-bit word.
  - Has its own synchronous clear, driven by `rst` or `start`.
- Top level holds the FSM, word index, N register and counters. Expected size is 150–250 lines.

## Test plan
- Reset then `start`; header 0x03,0x00; bytes 0x13,0x05,0x10,0x00, 0xB3,0x05,0xA5,0x00, 0x6F,0x00,0x00,0x00:
  - Writes (0,0x00100513), (1,0x00A505B3), (2,0x0000006F).
  - `done`=1, `cpu_hold`=0 one cycle after the last write. `words_loaded`=3.
- Header 0x00,0x00: no `im_we` pulse; `done`=1 and `cpu_hold`=0 at the edge the second header byte is accepted.
- Header 0x01,0x01 (N=257, DEPTH_WORDS=256): `err`=1, `rx_ready`=0, `cpu_hold` stays 1, no writes. A following `start` clears `err` and returns to HDR0.
- `rx_valid` toggled randomly with 30% idle cycles over N=8 words: contents and order are identical to the back-to-back case. `im_we` pulses exactly 8 times.
- `rst` asserted after 2 bytes of word 1 in an N=4 load: all outputs return to reset values next edge. A new `start` plus a full N=4 image writes indices 0–3 correctly, with no stale bytes.
- `start` pulsed during DATA: ignored; the load completes normally.
